udma_apb_master: RTL and testbench

- Single-outstanding APB initiator. Converts a simple valid/ready register-request interface into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Used where uDMA-side logic must program APB targets, i.e. the master end of the peripheral configuration bus.
- Adds wait-state handling, PSLVERR capture and a watchdog timeout for targets that never assert PREADY.

---
 rtl/udma_apb_master_if.sv | 37 +++
 rtl/udma_apb_master.sv | 108 ++++++++++
 tb/tb_udma_apb_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/udma_apb_master_if.sv
// Request/response channel and APB bus bundle for udma_apb_master.
// master = initiator side (the DUT), slave = request source plus APB target.
interface udma_apb_master_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]               req_wdata_i;
    logic                      req_rwn_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [31:0]               rsp_rdata_o;
    logic                      rsp_err_o;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_addr_i, req_wdata_i, req_rwn_i, rsp_ready_i,
               PRDATA, PREADY, PSLVERR,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid_i, req_addr_i, req_wdata_i, req_rwn_i, rsp_ready_i,
               PRDATA, PREADY, PSLVERR,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/udma_apb_master.sv
// Single-outstanding APB initiator: valid/ready request -> SETUP/ACCESS transfer
// -> valid/ready response, with wait states, PSLVERR capture and ACCESS watchdog.
module udma_apb_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                clk_i,
    input logic                rst_i,
    udma_apb_master_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    state_t                    state_next;
    logic [15:0]               wait_cnt;
    logic                      timeout_hit;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]               pwdata_q;
    logic                      pwrite_q;
    logic [31:0]               rdata_q;
    logic                      err_q;

    // Counter holds the number of ACCESS cycles already spent waiting,
    // so the abort lands on the TIMEOUT_CYCLES-th ACCESS cycle.
    assign timeout_hit = TIMEOUT_EN && !bus.PREADY && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        bus.req_ready_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.PSEL        = 1'b0;
        bus.PENABLE     = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                bus.PSEL   = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
                if (bus.PREADY || timeout_hit) state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        paddr_q  <= {bus.req_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                        pwdata_q <= bus.req_wdata_i;
                        pwrite_q <= ~bus.req_rwn_i;
                    end
                end
                ST_SETUP: wait_cnt <= '0;
                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        rdata_q <= (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
                        err_q   <= bus.PSLVERR;
                    end else begin
                        if (wait_cnt != '1) wait_cnt <= wait_cnt + 16'd1;
                        if (timeout_hit) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_udma_apb_master.sv
// Bench for udma_apb_master: directed vector table, random transfers scored
// against a transfer-level model, and an asynchronous reset during ACCESS.
module tb_udma_apb_master;
    localparam int unsigned AW = 12;
    localparam int unsigned TO = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          rwn;
        int unsigned   waits;
        logic          slverr;
        logic [31:0]   prdata;
        int unsigned   hold;
        logic          keep;
        logic [AW-1:0] exp_paddr;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int unsigned   exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    udma_apb_master_if #(.APB_ADDR_WIDTH(AW)) bus ();

    udma_apb_master #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [AW-1:0] addr, input logic [31:0] wdata,
                                 input logic rwn, input int unsigned waits, input logic slverr,
                                 input logic [31:0] prdata, input int unsigned hold, input logic keep,
                                 input logic [AW-1:0] exp_paddr, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int unsigned exp_lat);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.rwn = rwn; v.waits = waits; v.slverr = slverr;
        v.prdata = prdata; v.hold = hold; v.keep = keep; v.exp_paddr = exp_paddr;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Transfer-level reference: target answers after 'waits' stalled ACCESS
    // cycles unless the watchdog expires first.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic timed_out;
        timed_out   = (TO != 0) && (v.waits >= TO);
        r.exp_paddr = v.addr & ~AW'(3);
        r.exp_err   = timed_out || v.slverr;
        r.exp_rdata = (v.rwn && !r.exp_err) ? v.prdata : 32'h0;
        r.exp_lat   = 3 + (timed_out ? TO - 1 : v.waits);
        return r;
    endfunction

    task automatic junk_apb();
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'($urandom);
    endtask

    // Called at a negedge in the IDLE cycle; returns at the negedge of the IDLE
    // cycle that follows the response handshake.
    task automatic run_xfer(input vec_t v);
        chk("idle_req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("idle_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = v.addr;
        bus.req_wdata_i = v.wdata;
        bus.req_rwn_i   = v.rwn;
        bus.rsp_ready_i = 1'b0;
        junk_apb();
        for (int unsigned c = 1; c <= v.exp_lat; c++) begin
            @(negedge clk);
            if (!v.keep) begin
                bus.req_valid_i = 1'b0;
                bus.req_addr_i  = AW'($urandom);
                bus.req_wdata_i = $urandom;
                bus.req_rwn_i   = 1'($urandom);
            end
            bus.rsp_ready_i = (c < v.exp_lat) ? 1'($urandom) : 1'b0;
            junk_apb();
            chk("busy_req_ready", 32'(bus.req_ready_o), 32'd0);
            chk("psel", 32'(bus.PSEL), 32'(c < v.exp_lat));
            chk("penable", 32'(bus.PENABLE), 32'(c >= 2 && c < v.exp_lat));
            chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(c == v.exp_lat));
            if (c < v.exp_lat) begin
                chk("paddr", 32'(bus.PADDR), 32'(v.exp_paddr));
                chk("pwrite", 32'(bus.PWRITE), 32'(!v.rwn));
                chk("pwdata", bus.PWDATA, v.wdata);
            end
            if (c >= 2 && c < v.exp_lat) begin
                bus.PREADY = (c - 2 == v.waits);
                if (bus.PREADY) begin
                    bus.PRDATA  = v.prdata;
                    bus.PSLVERR = v.slverr;
                end
            end
        end
        chk("rsp_rdata", bus.rsp_rdata_o, v.exp_rdata);
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(v.exp_err));
        for (int unsigned h = 0; h < v.hold; h++) begin
            @(negedge clk);
            junk_apb();
            chk("hold_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("hold_rdata", bus.rsp_rdata_o, v.exp_rdata);
            chk("hold_err", 32'(bus.rsp_err_o), 32'(v.exp_err));
            chk("hold_req_ready", 32'(bus.req_ready_o), 32'd0);
            chk("hold_psel", 32'(bus.PSEL), 32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        junk_apb();
        chk("post_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("post_req_ready", 32'(bus.req_ready_o), 32'd1);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_rwn_i   = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.PRDATA      = '0;
        bus.PREADY      = 1'b0;
        bus.PSLVERR     = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_penable", 32'(bus.PENABLE), 32'd0);
        chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        chk("rst_paddr", 32'(bus.PADDR), 32'd0);
        chk("rst_pwdata", bus.PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        tbl.push_back(mkv(12'h084, 32'hDEADBEEF, 1'b0, 0, 1'b0, 32'hCAFEF00D, 0, 1'b0, 12'h084, 32'h0,        1'b0, 3));
        tbl.push_back(mkv(12'h103, 32'h11111111, 1'b1, 3, 1'b0, 32'h12345678, 0, 1'b0, 12'h100, 32'h12345678, 1'b0, 6));
        tbl.push_back(mkv(12'h200, 32'h22222222, 1'b1, 0, 1'b1, 32'hA5A5A5A5, 0, 1'b0, 12'h200, 32'h0,        1'b1, 3));
        tbl.push_back(mkv(12'h204, 32'h33333333, 1'b1, 1, 1'b0, 32'h0BADCAFE, 0, 1'b0, 12'h204, 32'h0BADCAFE, 1'b0, 4));
        tbl.push_back(mkv(12'h3FC, 32'h44444444, 1'b1, 7, 1'b0, 32'h77777777, 0, 1'b0, 12'h3FC, 32'h0,        1'b1, 6));
        tbl.push_back(mkv(12'h3FD, 32'h55555555, 1'b1, 3, 1'b0, 32'h55AA55AA, 0, 1'b0, 12'h3FC, 32'h55AA55AA, 1'b0, 6));
        tbl.push_back(mkv(12'hFFF, 32'h66666666, 1'b1, 2, 1'b0, 32'h0F0F0F0F, 5, 1'b1, 12'hFFC, 32'h0F0F0F0F, 1'b0, 5));
        tbl.push_back(mkv(12'h010, 32'h77777777, 1'b1, 0, 1'b0, 32'h89ABCDEF, 0, 1'b0, 12'h010, 32'h89ABCDEF, 1'b0, 3));
        tbl.push_back(mkv(12'h040, 32'h88888888, 1'b0, 0, 1'b1, 32'hFFFFFFFF, 1, 1'b0, 12'h040, 32'h0,        1'b1, 3));
        foreach (tbl[i]) run_xfer(tbl[i]);

        // Reset while the target is stalling in ACCESS.
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 12'h0A4;
        bus.req_rwn_i   = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.PREADY      = 1'b0;
        repeat (2) @(negedge clk);
        bus.PREADY = 1'b0;
        chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_psel", 32'(bus.PSEL), 32'd0);
        chk("async_penable", 32'(bus.PENABLE), 32'd0);
        chk("async_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rel_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rel_psel", 32'(bus.PSEL), 32'd0);
        chk("rel_rsp_err", 32'(bus.rsp_err_o), 32'd0);

        for (int unsigned i = 0; i < 40; i++) begin
            rv.addr   = AW'($urandom);
            rv.wdata  = $urandom;
            rv.rwn    = 1'($urandom);
            rv.waits  = $urandom_range(0, 6);
            rv.slverr = ($urandom_range(0, 3) == 0);
            rv.prdata = $urandom;
            rv.hold   = $urandom_range(0, 3);
            rv.keep   = (i < 39) ? 1'($urandom) : 1'b0;
            run_xfer(model(rv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end
endmodule
